d05200_otp_ctrl: RTL and testbench

- Sequencer between the digital core and the 128x8 OTP macro.
- After reset it boot-loads trim and config bytes from OTP into shadow registers. These feed the oscillator trims (HCFR/LCFR) and core config.
- Afterwards it serves single-byte host read/program requests from the one-wire test path.
- It owns all CS/READ/PROG timing so that no other block drives the macro directly.

---
 rtl/d05200_otp_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_d05200_otp_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d05200_otp_ctrl.sv
// Sequencer for the 128x8 OTP macro: after reset it loads the trim and config shadows from OTP,
// then serves single-byte host read/program requests. Optional boot checksum: define OTP_CHKSUM_EN.
module d05200_otp_ctrl #(
    parameter int BOOT_BYTES = 4,
    parameter int SETUP_CYC  = 1,
    parameter int RD_CYC     = 3,
    parameter int PRG_CYC    = 200
) (
    input  logic       HCLK,
    input  logic       RESET,
    input  logic       REQ,
    input  logic       WR,
    input  logic [6:0] ADDR,
    input  logic [7:0] WDATA,
    output logic       ACK,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       BOOT_DONE,
    output logic       CHK_ERR,
    output logic [7:0] TRIM_HCFR,
    output logic [3:0] TRIM_LCFR,
    output logic [7:0] CFG0,
    output logic [7:0] CFG1,
    output logic       OTP_CS,
    output logic       OTP_READ,
    output logic       OTP_PROG,
    output logic [6:0] OTP_ADDR,
    output logic [7:0] OTP_DATI,
    input  logic [7:0] OTP_DATO,
    output logic [2:0] dbg_state
);

    // Host handshake: REQ is a level request. WR/ADDR/WDATA are sampled in the IDLE cycle where
    // REQ is seen (BOOT_DONE=1); ACK pulses for one cycle in the last HOLD cycle; a REQ still high
    // back in IDLE starts the next access. REQ is neither served nor acknowledged during boot.

`ifdef OTP_CHKSUM_EN
    localparam int BOOT_READS = BOOT_BYTES + 1;
`else
    localparam int BOOT_READS = BOOT_BYTES;
`endif
    localparam int BW = $clog2(BOOT_READS + 1);

    localparam int MAX_CYC = (PRG_CYC > RD_CYC) ?
                             ((PRG_CYC > SETUP_CYC) ? PRG_CYC : SETUP_CYC) :
                             ((RD_CYC > SETUP_CYC) ? RD_CYC : SETUP_CYC);
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] RD_LAST    = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] PRG_LAST   = CW'(PRG_CYC - 1);
    localparam logic [BW-1:0] BOOT_END   = BW'(BOOT_READS);

    typedef enum logic [2:0] {
        BOOT_IDLE = 3'd0,
        IDLE      = 3'd1,
        SETUP     = 3'd2,
        STROBE    = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] boot_cnt_q;
    logic          op_host_q;
    logic          op_wr_q;
    logic          cs_q, rd_q, prog_q;
    logic [6:0]    addr_q;
    logic [7:0]    dati_q;
    logic [7:0]    rdata_q;
    logic          boot_done_q;
    logic [7:0]    hcfr_q, cfg0_q, cfg1_q;
    logic [3:0]    lcfr_q;

    logic          start_boot, start_host, capture, hold_end;
    logic [CW-1:0] strobe_last;
    logic          in_access_d;

    assign strobe_last = op_wr_q ? PRG_LAST : RD_LAST;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_boot = 1'b0;
        start_host = 1'b0;
        capture    = 1'b0;
        hold_end   = 1'b0;
        case (state_q)
            BOOT_IDLE: begin
                state_d    = SETUP;
                start_boot = 1'b1;
            end
            IDLE: begin
                // Boot keeps priority until every boot byte has been read.
                if (!boot_done_q) begin
                    state_d    = SETUP;
                    start_boot = 1'b1;
                end else if (REQ) begin
                    state_d    = SETUP;
                    start_host = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == strobe_last) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    capture = !op_wr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    hold_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = BOOT_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Macro strobes come straight from flops so the OTP never sees decode glitches.
    assign in_access_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

`ifdef OTP_CHKSUM_EN
    logic [7:0] sum_q;
    logic       chk_err_q;
    assign CHK_ERR = chk_err_q;
`else
    assign CHK_ERR = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= BOOT_IDLE;
            cnt_q       <= '0;
            boot_cnt_q  <= '0;
            op_host_q   <= 1'b0;
            op_wr_q     <= 1'b0;
            cs_q        <= 1'b0;
            rd_q        <= 1'b0;
            prog_q      <= 1'b0;
            addr_q      <= 7'h00;
            dati_q      <= 8'h00;
            rdata_q     <= 8'h00;
            boot_done_q <= 1'b0;
            hcfr_q      <= 8'h80;
            lcfr_q      <= 4'h8;
            cfg0_q      <= 8'h00;
            cfg1_q      <= 8'h00;
`ifdef OTP_CHKSUM_EN
            sum_q       <= 8'h00;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= in_access_d;
            rd_q    <= (state_d == STROBE) && !op_wr_q;
            prog_q  <= (state_d == STROBE) && op_wr_q;

            if (start_boot) begin
                op_host_q <= 1'b0;
                op_wr_q   <= 1'b0;
                addr_q    <= 7'(boot_cnt_q);
                dati_q    <= 8'h00;
            end
            if (start_host) begin
                op_host_q <= 1'b1;
                op_wr_q   <= WR;
                addr_q    <= ADDR;
                dati_q    <= WDATA;
            end

            if (capture && op_host_q) begin
                rdata_q <= OTP_DATO;
            end

            if (capture && !op_host_q) begin
                if (boot_cnt_q != BOOT_END) begin
                    boot_cnt_q <= boot_cnt_q + 1'b1;
                end
                // Boot bytes past the fourth (and the checksum byte) are read but not stored.
                if (int'(boot_cnt_q) < BOOT_BYTES) begin
                    case (int'(boot_cnt_q))
                        0:       hcfr_q <= OTP_DATO;
                        1:       lcfr_q <= OTP_DATO[3:0];
                        2:       cfg0_q <= OTP_DATO;
                        3:       cfg1_q <= OTP_DATO;
                        default: ;
                    endcase
                end
`ifdef OTP_CHKSUM_EN
                sum_q <= sum_q + OTP_DATO;
`endif
            end

            if (hold_end && !op_host_q && (boot_cnt_q == BOOT_END)) begin
                boot_done_q <= 1'b1;
`ifdef OTP_CHKSUM_EN
                // A bad image must not reach the oscillators: fall back to mid-scale trims.
                if (sum_q != 8'hFF) begin
                    chk_err_q <= 1'b1;
                    hcfr_q    <= 8'h80;
                    lcfr_q    <= 4'h8;
                    cfg0_q    <= 8'h00;
                    cfg1_q    <= 8'h00;
                end
`endif
            end
        end
    end

    assign ACK       = (state_q == HOLD) && (cnt_q == SETUP_LAST) && op_host_q;
    // Combinational so BUSY already covers the IDLE cycle in which a request is latched.
    assign BUSY      = !RESET && ((state_q != IDLE) || !boot_done_q || REQ);
    assign RDATA     = rdata_q;
    assign BOOT_DONE = boot_done_q;
    assign TRIM_HCFR = hcfr_q;
    assign TRIM_LCFR = lcfr_q;
    assign CFG0      = cfg0_q;
    assign CFG1      = cfg1_q;
    assign OTP_CS    = cs_q;
    assign OTP_READ  = rd_q;
    assign OTP_PROG  = prog_q;
    assign OTP_ADDR  = addr_q;
    assign OTP_DATI  = dati_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_d05200_otp_ctrl.sv
// Directed bench for d05200_otp_ctrl: OTP macro model, access monitor, and a linear sequence of
// boot / host read / host program / reset-abort / level-REQ steps checked with immediate assertions.
module tb_d05200_otp_ctrl;

    logic       HCLK;
    logic       RESET;
    logic       REQ;
    logic       WR;
    logic [6:0] ADDR;
    logic [7:0] WDATA;
    logic       ACK;
    logic [7:0] RDATA;
    logic       BUSY;
    logic       BOOT_DONE;
    logic       CHK_ERR;
    logic [7:0] TRIM_HCFR;
    logic [3:0] TRIM_LCFR;
    logic [7:0] CFG0;
    logic [7:0] CFG1;
    logic       OTP_CS;
    logic       OTP_READ;
    logic       OTP_PROG;
    logic [6:0] OTP_ADDR;
    logic [7:0] OTP_DATI;
    logic [7:0] OTP_DATO;
    logic [2:0] dbg_state;

`ifdef OTP_CHKSUM_EN
    localparam int  BOOT_RD = 5;
`else
    localparam int  BOOT_RD = 4;
`endif
    localparam int BOOT_LAT = 6 * BOOT_RD;

    d05200_otp_ctrl dut (
        .HCLK      (HCLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .WR        (WR),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .ACK       (ACK),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .BOOT_DONE (BOOT_DONE),
        .CHK_ERR   (CHK_ERR),
        .TRIM_HCFR (TRIM_HCFR),
        .TRIM_LCFR (TRIM_LCFR),
        .CFG0      (CFG0),
        .CFG1      (CFG1),
        .OTP_CS    (OTP_CS),
        .OTP_READ  (OTP_READ),
        .OTP_PROG  (OTP_PROG),
        .OTP_ADDR  (OTP_ADDR),
        .OTP_DATI  (OTP_DATI),
        .OTP_DATO  (OTP_DATO),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- OTP macro model ----------------
    logic [7:0] mem [128];
    assign OTP_DATO = OTP_READ ? mem[OTP_ADDR] : 8'h00;

    // ---------------- access monitor ----------------
    int lg_cs[$], lg_rd[$], lg_pr[$], lg_off[$], lg_gap[$], lg_addr[$], lg_dati[$], lg_stab[$];
    int cs_len, rd_len, pr_len, rd_off, gap_len, cur_gap, stab;
    logic [6:0] a0;
    logic [7:0] d0;
    logic cs_prev;
    int ack_cnt, ack_early;

    initial begin
        cs_prev   = 1'b0;
        gap_len   = 0;
        ack_cnt   = 0;
        ack_early = 0;
    end

    always @(negedge HCLK) begin
        if (OTP_CS) begin
            if (!cs_prev) begin
                cs_len  = 0;
                rd_len  = 0;
                pr_len  = 0;
                rd_off  = -1;
                a0      = OTP_ADDR;
                d0      = OTP_DATI;
                stab    = 1;
                cur_gap = gap_len;
            end
            if ((OTP_READ || OTP_PROG) && rd_off < 0) rd_off = cs_len;
            cs_len++;
            if (OTP_READ) rd_len++;
            if (OTP_PROG) pr_len++;
            if (OTP_ADDR != a0 || OTP_DATI != d0) stab = 0;
        end else begin
            if (cs_prev) begin
                lg_cs.push_back(cs_len);
                lg_rd.push_back(rd_len);
                lg_pr.push_back(pr_len);
                lg_off.push_back(rd_off);
                lg_gap.push_back(cur_gap);
                lg_addr.push_back(int'(a0));
                lg_dati.push_back(int'(d0));
                lg_stab.push_back(stab);
                gap_len = 1;
            end else begin
                gap_len++;
            end
        end
        if (ACK) begin
            ack_cnt++;
            if (!BOOT_DONE) ack_early++;
        end
        cs_prev = OTP_CS;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_cmp;
    int n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic chk_rdata(input string tag);
        logic [7:0] want;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk(tag, {24'h0, RDATA}, {24'h0, want});
    endtask

    task automatic clear_log();
        lg_cs.delete(); lg_rd.delete(); lg_pr.delete(); lg_off.delete();
        lg_gap.delete(); lg_addr.delete(); lg_dati.delete(); lg_stab.delete();
    endtask

    task automatic pop_log(output int cs, output int rd, output int pr, output int off,
                           output int gap, output int addr, output int dati, output int st);
        if (lg_cs.size() == 0) begin
            cs = -1; rd = -1; pr = -1; off = -1; gap = -1; addr = -1; dati = -1; st = -1;
        end else begin
            cs   = lg_cs.pop_front();
            rd   = lg_rd.pop_front();
            pr   = lg_pr.pop_front();
            off  = lg_off.pop_front();
            gap  = lg_gap.pop_front();
            addr = lg_addr.pop_front();
            dati = lg_dati.pop_front();
            st   = lg_stab.pop_front();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_boot(input int limit, output int lat);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge HCLK);
            n++;
            hit = (BOOT_DONE === 1'b1);
        end
        lat = hit ? n : -1;
        #1;
    endtask

    task automatic wait_ack(input int limit, output int lat);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge HCLK);
            n++;
            hit = (ACK === 1'b1);
        end
        lat = hit ? n : -1;
        #1;
    endtask

    task automatic host_req(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        WR    = wr;
        ADDR  = addr;
        WDATA = wdata;
        REQ   = 1'b1;
    endtask

    task automatic chk_boot_log(input string tag);
        int cs, rd, pr, off, gap, addr, dati, st;
        for (int k = 0; k < BOOT_RD; k++) begin
            pop_log(cs, rd, pr, off, gap, addr, dati, st);
            chk({tag, "_addr"}, addr, k);
            chk({tag, "_cs"}, cs, 5);
            chk({tag, "_rd"}, rd, 3);
            chk({tag, "_pr"}, pr, 0);
            chk({tag, "_off"}, off, 1);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, acks_before, k;
        int cs, rd, pr, off, gap, addr, dati, st;

        n_cmp  = 0;
        n_fail = 0;
        RESET  = 1'b1;
        REQ    = 1'b0;
        WR     = 1'b0;
        ADDR   = 7'h00;
        WDATA  = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[0] = 8'h5A;
        mem[1] = 8'h0C;
        mem[2] = 8'h11;
        mem[3] = 8'h22;
        // 5A+0C+11+22 = 99, so 66 makes the modulo sum FF.
        mem[4] = 8'h66;
        mem[7'h40] = 8'hA5;

        // Reset values while RESET is held.
        #2;
        chk("rst_cs", OTP_CS, 0);
        chk("rst_read", OTP_READ, 0);
        chk("rst_prog", OTP_PROG, 0);
        chk("rst_addr", OTP_ADDR, 0);
        chk("rst_dati", OTP_DATI, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", BOOT_DONE, 0);
        chk("rst_chkerr", CHK_ERR, 0);
        chk("rst_hcfr", TRIM_HCFR, 8'h80);
        chk("rst_lcfr", TRIM_LCFR, 4'h8);
        chk("rst_cfg0", CFG0, 0);
        chk("rst_cfg1", CFG1, 0);

        // Boot.
        repeat (2) @(negedge HCLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("boot_busy_start", BUSY, 1);
        wait_boot(200, lat);
        chk("boot_latency", lat, BOOT_LAT);
        chk("boot_nacc", lg_cs.size(), BOOT_RD);
        chk_boot_log("boot1");
        chk("boot_hcfr", TRIM_HCFR, 8'h5A);
        chk("boot_lcfr", TRIM_LCFR, 4'hC);
        chk("boot_cfg0", CFG0, 8'h11);
        chk("boot_cfg1", CFG1, 8'h22);
        chk("boot_chkerr", CHK_ERR, 0);
        chk("boot_busy_end", BUSY, 0);
        chk("boot_no_ack", ack_cnt, 0);

        // Host read of 0x40.
        host_req(1'b0, 7'h40, 8'h00);
        exp_q.push_back(8'hA5);
        #1;
        chk("rd_busy_latch", BUSY, 1);
        wait_ack(20, lat);
        chk("rd_ack_lat", lat, 5);
        chk_rdata("rd_rdata");
        REQ = 1'b0;
        @(negedge HCLK);
        #1;
        chk("rd_ack_pulse", ACK, 0);
        chk("rd_ack_cnt", ack_cnt, 1);
        pop_log(cs, rd, pr, off, gap, addr, dati, st);
        chk("rd_cs", cs, 5);
        chk("rd_rd", rd, 3);
        chk("rd_pr", pr, 0);
        chk("rd_addr", addr, 7'h40);
        chk("rd_stable", st, 1);
        chk("rd_hcfr_keep", TRIM_HCFR, 8'h5A);
        chk("rd_cfg1_keep", CFG1, 8'h22);

        // Host program 0x3C into 0x7F.
        host_req(1'b1, 7'h7F, 8'h3C);
        wait_ack(400, lat);
        chk("pg_ack_lat", lat, 202);
        REQ = 1'b0;
        @(negedge HCLK);
        #1;
        chk("pg_rdata_keep", RDATA, 8'hA5);
        pop_log(cs, rd, pr, off, gap, addr, dati, st);
        chk("pg_cs", cs, 202);
        chk("pg_prog", pr, 200);
        chk("pg_rd", rd, 0);
        chk("pg_off", off, 1);
        chk("pg_addr", addr, 7'h7F);
        chk("pg_dati", dati, 8'h3C);
        chk("pg_stable", st, 1);
        chk("pg_lcfr_keep", TRIM_LCFR, 4'hC);

        // Reset in PROG cycle 50, with REQ held high through the reboot.
        host_req(1'b1, 7'h10, 8'h77);
        k = 0;
        while (!OTP_PROG && k < 20) begin
            @(negedge HCLK);
            k++;
        end
        chk("ab_prog_seen", OTP_PROG, 1);
        repeat (49) @(negedge HCLK);
        #1;
        acks_before = ack_cnt;
        RESET = 1'b1;
        #1;
        chk("ab_prog_drop", OTP_PROG, 0);
        chk("ab_cs_drop", OTP_CS, 0);
        chk("ab_hcfr", TRIM_HCFR, 8'h80);
        chk("ab_lcfr", TRIM_LCFR, 4'h8);
        chk("ab_cfg0", CFG0, 0);
        chk("ab_done", BOOT_DONE, 0);
        chk("ab_busy", BUSY, 0);
        WR   = 1'b0;
        ADDR = 7'h40;
        repeat (2) @(negedge HCLK);
        #1;
        clear_log();
        RESET = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h0C);
        wait_boot(200, lat);
        chk("rb_latency", lat, BOOT_LAT);
        chk("rb_no_ack", ack_cnt, acks_before);
        chk("rb_ack_early", ack_early, 0);
        chk("rb_hcfr", TRIM_HCFR, 8'h5A);
        chk("rb_lcfr", TRIM_LCFR, 4'hC);
        chk("rb_cfg0", CFG0, 8'h11);

        // Level REQ: two back-to-back reads; ADDR changed mid-access feeds only the second one.
        @(negedge HCLK);
        #1;
        ADDR = 7'h01;
        wait_ack(20, lat);
        chk("lv1_ack_lat", lat, 4);
        chk_rdata("lv1_rdata");
        wait_ack(20, lat);
        chk("lv2_ack_lat", lat, 6);
        chk_rdata("lv2_rdata");
        REQ = 1'b0;
        @(negedge HCLK);
        #1;
        chk("lv_nacc", lg_cs.size(), BOOT_RD + 2);
        chk_boot_log("boot2");
        pop_log(cs, rd, pr, off, gap, addr, dati, st);
        chk("lv1_addr", addr, 7'h40);
        chk("lv1_gap", gap, 1);
        pop_log(cs, rd, pr, off, gap, addr, dati, st);
        chk("lv2_addr", addr, 7'h01);
        chk("lv2_gap", gap, 1);
        chk("lv2_cs", cs, 5);
        chk("lv_ack_early", ack_early, 0);

`ifdef OTP_CHKSUM_EN
        // Bad checksum byte: shadows fall back to reset values, boot still completes.
        mem[4] = 8'h00;
        RESET = 1'b1;
        @(negedge HCLK);
        #1;
        RESET = 1'b0;
        wait_boot(200, lat);
        chk("ck_latency", lat, BOOT_LAT);
        chk("ck_chkerr", CHK_ERR, 1);
        chk("ck_done", BOOT_DONE, 1);
        chk("ck_hcfr", TRIM_HCFR, 8'h80);
        chk("ck_lcfr", TRIM_LCFR, 4'h8);
        chk("ck_cfg0", CFG0, 0);
`endif

        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
